// File: rtl/rv32I_execute_pkg.sv
// ---------------------------------------------------------------------------
// rv32I_execute_pkg
// Types and widths shared by the execute-stage multiplier responder and its
// initiator.
// ---------------------------------------------------------------------------
package rv32I_execute_pkg;

    localparam int unsigned MUL_OPERAND_W = 16;
    localparam int unsigned MUL_RESULT_W  = 32;

    // MulRelease waits for the initiator to drop en before another capture.
    typedef enum logic [1:0] {
        MulIdle,
        MulBusy,
        MulDone,
        MulRelease
    } mul_state_e;

endpackage

// File: rtl/rv32i_multiplier_responder.sv
// ---------------------------------------------------------------------------
// rv32i_multiplier_responder
// Unsigned 16x16 -> 32 shift-and-add multiplier answering a level-held
// request. One multiplier bit is consumed per cycle; the run stops early as
// soon as the remaining multiplier bits are all zero.
//
// Ports
//   i_clk                     clock, rising edge
//   i_rst_n                   asynchronous active-low reset
//   i_multiplier_en           request, held high until valid is sampled
//   i_multiplier_operand_one  multiplicand (unsigned)
//   i_multiplier_operand_two  multiplier (unsigned)
//   o_multiplier_valid        one-cycle pulse, result is valid
//   o_multiplier_result       product, held until the next completion
// ---------------------------------------------------------------------------
module rv32i_multiplier_responder
    import rv32I_execute_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_multiplier_en,
    input  logic [MUL_OPERAND_W-1:0] i_multiplier_operand_one,
    input  logic [MUL_OPERAND_W-1:0] i_multiplier_operand_two,
    output logic                     o_multiplier_valid,
    output logic [MUL_RESULT_W-1:0]  o_multiplier_result
);

    localparam int unsigned ExtW = MUL_RESULT_W - MUL_OPERAND_W;

    mul_state_e                state_q, state_d;
    logic [MUL_RESULT_W-1:0]   mcand_q, mcand_d;
    logic [MUL_OPERAND_W-1:0]  mplier_q, mplier_d;
    logic [MUL_RESULT_W-1:0]   acc_q, acc_d;
    logic [MUL_RESULT_W-1:0]   result_q, result_d;
    logic                      valid_q, valid_d;

    logic mplier_zero;
    assign mplier_zero = (mplier_q == '0);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= MulIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MulIdle: begin
                if (i_multiplier_en) begin
                    state_d = MulBusy;
                end
            end
            MulBusy: begin
                // A dropped request abandons the run, even on its final cycle.
                if (!i_multiplier_en) begin
                    state_d = MulIdle;
                end else if (mplier_zero) begin
                    state_d = MulDone;
                end
            end
            MulDone: begin
                state_d = MulRelease;
            end
            MulRelease: begin
                if (!i_multiplier_en) begin
                    state_d = MulIdle;
                end
            end
            default: begin
                state_d = MulIdle;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and registered-output next values
    // -----------------------------------------------------------------------
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        valid_d  = 1'b0;
        unique case (state_q)
            MulIdle: begin
                if (i_multiplier_en) begin
                    mcand_d  = {{ExtW{1'b0}}, i_multiplier_operand_one};
                    mplier_d = i_multiplier_operand_two;
                    acc_d    = '0;
                end
            end
            MulBusy: begin
                if (i_multiplier_en) begin
                    if (!mplier_zero) begin
                        if (mplier_q[0]) begin
                            acc_d = acc_q + mcand_q;
                        end
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                    end else begin
                        result_d = acc_q;
                        valid_d  = 1'b1;
                    end
                end
            end
            MulDone, MulRelease: begin
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_multiplier_valid  = valid_q;
    assign o_multiplier_result = result_q;

endmodule

// File: tb/tb_rv32i_multiplier_responder.sv
module tb_rv32i_multiplier_responder;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_multiplier_en;
    logic [15:0] i_multiplier_operand_one;
    logic [15:0] i_multiplier_operand_two;
    logic        o_multiplier_valid;
    logic [31:0] o_multiplier_result;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_multiplier_responder dut (
        .i_clk                    (i_clk),
        .i_rst_n                  (i_rst_n),
        .i_multiplier_en          (i_multiplier_en),
        .i_multiplier_operand_one (i_multiplier_operand_one),
        .i_multiplier_operand_two (i_multiplier_operand_two),
        .o_multiplier_valid       (o_multiplier_valid),
        .o_multiplier_result      (o_multiplier_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Expected latency: 1 for a zero multiplier, else msb index + 2.
    function automatic int exp_latency(input logic [15:0] b);
        int msb;
        msb = -1;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) msb = i;
        end
        return (msb < 0) ? 1 : msb + 2;
    endfunction

    // Stimulus only: issue one request from Idle, count edges from the capture
    // edge to valid, measure pulse width, optionally hold en extra cycles,
    // then release en for one cycle. Returns at release edge + #1.
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int hold_extra,
                           output int lat, output logic [31:0] res, output int width,
                           output int extra_pulses, output int res_moved);
        i_multiplier_operand_one = a;
        i_multiplier_operand_two = b;
        i_multiplier_en          = 1'b1;
        @(posedge i_clk); #1;
        // Operands changed after capture must not matter.
        i_multiplier_operand_one = ~a;
        i_multiplier_operand_two = b ^ 16'h5A5A;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge i_clk); #1;
            if (o_multiplier_valid) begin
                lat = n;
                break;
            end
        end
        res          = o_multiplier_result;
        width        = (lat < 0) ? 0 : 1;
        extra_pulses = 0;
        res_moved    = 0;
        @(posedge i_clk); #1;
        if (o_multiplier_valid) width++;
        for (int k = 0; k < hold_extra; k++) begin
            @(posedge i_clk); #1;
            if (o_multiplier_valid) extra_pulses++;
            if (o_multiplier_result !== res) res_moved++;
        end
        i_multiplier_en = 1'b0;
        @(posedge i_clk); #1;
    endtask

    task automatic test_reset();
        i_rst_n                  = 1'b0;
        i_multiplier_en          = 1'b0;
        i_multiplier_operand_one = 16'h0;
        i_multiplier_operand_two = 16'h0;
        #12;
        n_checks++;
        if (o_multiplier_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got %b exp 0", o_multiplier_valid);
        end
        n_checks++;
        if (o_multiplier_result !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_result got %h exp 00000000", o_multiplier_result);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_basic();
        int lat, width, xp, mv;
        logic [31:0] res;
        run_mul(16'd3, 16'd5, 0, lat, res, width, xp, mv);
        n_checks++;
        if (res !== 32'h0000000F) begin
            n_fail++;
            $display("FAIL basic_result got %h exp 0000000f", res);
        end
        n_checks++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL basic_latency got %0d exp 4", lat);
        end
        n_checks++;
        if (width !== 1) begin
            n_fail++;
            $display("FAIL basic_pulse_width got %0d exp 1", width);
        end
    endtask

    task automatic test_extremes();
        int lat, width, xp, mv;
        logic [31:0] res;
        run_mul(16'hFFFF, 16'hFFFF, 0, lat, res, width, xp, mv);
        n_checks++;
        if (res !== 32'hFFFE0001) begin
            n_fail++;
            $display("FAIL max_result got %h exp fffe0001", res);
        end
        n_checks++;
        if (lat !== 17) begin
            n_fail++;
            $display("FAIL max_latency got %0d exp 17", lat);
        end
        run_mul(16'h1234, 16'h0000, 0, lat, res, width, xp, mv);
        n_checks++;
        if (res !== 32'h0) begin
            n_fail++;
            $display("FAIL zero_result got %h exp 00000000", res);
        end
        n_checks++;
        if (lat !== 1) begin
            n_fail++;
            $display("FAIL zero_latency got %0d exp 1", lat);
        end
        n_checks++;
        if (width !== 1) begin
            n_fail++;
            $display("FAIL zero_pulse_width got %0d exp 1", width);
        end
    endtask

    task automatic test_back_to_back();
        int lat, width, xp, mv;
        logic [31:0] res;
        run_mul(16'h0001, 16'h0010, 0, lat, res, width, xp, mv);
        n_checks++;
        if (res !== 32'h00000010 || lat !== 6) begin
            n_fail++;
            $display("FAIL b2b_first got %h lat %0d exp 00000010 lat 6", res, lat);
        end
        run_mul(16'h8000, 16'h0002, 0, lat, res, width, xp, mv);
        n_checks++;
        if (res !== 32'h00010000 || lat !== 3) begin
            n_fail++;
            $display("FAIL b2b_second got %h lat %0d exp 00010000 lat 3", res, lat);
        end
        n_checks++;
        if (width !== 1) begin
            n_fail++;
            $display("FAIL b2b_pulse_width got %0d exp 1", width);
        end
    endtask

    task automatic test_abort();
        int lat, width, xp, mv, pulses;
        logic [31:0] res;
        logic [31:0] prev;
        prev = o_multiplier_result;
        i_multiplier_operand_one = 16'h00FF;
        i_multiplier_operand_two = 16'h8000;
        i_multiplier_en          = 1'b1;
        @(posedge i_clk); #1;
        repeat (4) begin
            @(posedge i_clk); #1;
        end
        // en low at the 5th MulBusy edge.
        i_multiplier_en = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(posedge i_clk); #1;
            if (o_multiplier_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_valid got %0d pulses exp 0", pulses);
        end
        n_checks++;
        if (o_multiplier_result !== 32'h00010000) begin
            n_fail++;
            $display("FAIL abort_result_kept got %h exp 00010000 (before %h)",
                     o_multiplier_result, prev);
        end
        run_mul(16'd7, 16'd9, 0, lat, res, width, xp, mv);
        n_checks++;
        if (res !== 32'h0000003F || lat !== 5) begin
            n_fail++;
            $display("FAIL after_abort got %h lat %0d exp 0000003f lat 5", res, lat);
        end
    endtask

    task automatic test_reset_mid();
        int lat, width, xp, mv, pulses;
        logic [31:0] res;
        i_multiplier_operand_one = 16'hABCD;
        i_multiplier_operand_two = 16'h00FF;
        i_multiplier_en          = 1'b1;
        @(posedge i_clk); #1;
        repeat (3) begin
            @(posedge i_clk); #1;
        end
        #1;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_multiplier_valid !== 1'b0 || o_multiplier_result !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs got valid %b result %h exp 0 00000000",
                     o_multiplier_valid, o_multiplier_result);
        end
        i_multiplier_en = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(posedge i_clk); #1;
            if (o_multiplier_valid) pulses++;
        end
        i_rst_n = 1'b1;
        repeat (20) begin
            @(posedge i_clk); #1;
            if (o_multiplier_valid) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midreset_no_valid got %0d pulses exp 0", pulses);
        end
        run_mul(16'd2, 16'd2, 0, lat, res, width, xp, mv);
        n_checks++;
        if (res !== 32'h00000004 || lat !== 3) begin
            n_fail++;
            $display("FAIL after_reset got %h lat %0d exp 00000004 lat 3", res, lat);
        end
    endtask

    task automatic test_hold_en_random();
        int lat, width, xp, mv;
        logic [31:0] res;
        logic [15:0] a, b;
        logic [31:0] exp_p;
        for (int t = 0; t < 8; t++) begin
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            if (t == 0) b = 16'h0003;
            exp_p = {16'h0, a} * {16'h0, b};
            run_mul(a, b, 3, lat, res, width, xp, mv);
            n_checks++;
            if (res !== exp_p || lat !== exp_latency(b)) begin
                n_fail++;
                $display("FAIL rand_%0d %h*%h got %h lat %0d exp %h lat %0d",
                         t, a, b, res, lat, exp_p, exp_latency(b));
            end
            n_checks++;
            if (xp !== 0 || mv !== 0 || width !== 1) begin
                n_fail++;
                $display("FAIL hold_%0d got pulses %0d moved %0d width %0d exp 0 0 1",
                         t, xp, mv, width);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_hold_en_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv32i_multiplier_responder.md
RV32I_MULTIPLIER_RESPONDER -- requirements
Module: rv32I_multiplier_responder

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 16 bits and result width at 32 bits.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 i_clk  input  1  clock; all state updates on its rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_multiplier_en  input  1  request, held high by the initiator until it samples valid.
REQ-006 i_multiplier_operand_one  input  16  multiplicand, unsigned.
REQ-007 i_multiplier_operand_two  input  16  multiplier, unsigned.
REQ-008 o_multiplier_valid  output  1  one-cycle pulse marking the result as valid.
REQ-009 o_multiplier_result  output  32  unsigned product; held stable until the next capture.

Function
REQ-010 The FSM SHALL have exactly four states: MulIdle, MulBusy, MulDone and MulRelease.
REQ-011 MulIdle: on an edge with i_multiplier_en=1, the block SHALL capture operand_one zero-extended to 32 bits, capture operand_two into a 16-bit shift register, clear a 32-bit accumulator and go to MulBusy.
REQ-012 MulBusy, multiplier register nonzero: if bit0=1, add the multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; stay in MulBusy.
REQ-013 MulBusy, multiplier register zero: the block SHALL load o_multiplier_result from the accumulator, set o_multiplier_valid=1 and go to MulDone.
REQ-014 Latency, counted in edges from the capture edge to the valid-setting edge, SHALL be 1 when operand_two=0, and msb_index(operand_two)+2 otherwise. The maximum is 17.
REQ-015 MulDone: o_multiplier_valid SHALL return to 0 and the FSM SHALL go to MulRelease. Valid is therefore high for exactly one cycle.
REQ-016 MulRelease: the block SHALL stay in MulRelease while i_multiplier_en=1 and go to MulIdle on the first edge with i_multiplier_en=0. A new request SHALL never be captured without an intervening low cycle of en.
REQ-017 The block SHALL accept back-to-back transactions with a one-cycle en-low gap; this is the initiator's pattern.
REQ-018 If i_multiplier_en=0 is sampled in MulBusy, the block SHALL abort: go to MulIdle with no valid pulse, and leave o_multiplier_result unchanged.
REQ-019 Operand changes after the capture edge SHALL have no effect on the transaction in flight.
REQ-020 All arithmetic SHALL be unsigned modulo 2^32. Overflow is impossible because 0xFFFF*0xFFFF = 0xFFFE0001.
REQ-021 The outputs SHALL be registered; there SHALL be no combinational path from the inputs to the outputs.

Reset
REQ-022 Assertion of i_rst_n=0 SHALL immediately force MulIdle, o_multiplier_valid=0, o_multiplier_result=0, and clear the accumulator, multiplicand and multiplier registers.
REQ-023 Reset asserted mid-transaction SHALL discard that transaction with no valid pulse. After deassertion, the first edge with en=1 SHALL start a fresh capture.

Structure
REQ-024 The state enum and the localparams MUL_OPERAND_W=16 and MUL_RESULT_W=32 SHALL reside in a shared package, rv32I_execute_pkg, imported by this block and by the initiator.
REQ-025 The block SHALL be implemented as a single flat module; no sub-module is warranted.

Verification
REQ-026 Request 3 x 5 -> o_multiplier_result=0x0000000F with valid on edge 4 after capture, for exactly one cycle.
REQ-027 Request 0xFFFF x 0xFFFF -> result 0xFFFE0001 at latency 17; request 0x1234 x 0x0000 -> result 0 at latency 1.
REQ-028 Back-to-back requests with a one-cycle en gap: 0x0001 x 0x0010 -> 0x00000010 (latency 6); then 0x8000 x 0x0002 -> 0x00010000 (latency 3). Both valid pulses SHALL be present.
REQ-029 Request 0x00FF x 0x8000 with en dropped on the 5th MulBusy cycle -> no valid pulse and the result is unchanged. A following 7 x 9 -> 0x0000003F at latency 5.
REQ-030 Request 0xABCD x 0x00FF with i_rst_n pulsed low mid-MulBusy -> outputs are 0 immediately with no valid pulse. After release, 2 x 2 -> 0x00000004 at latency 3.
REQ-031 In a random-operand run, hold en high after valid for 3 extra cycles -> no recapture until en falls, and each result equals op1*op2.
